// File: rtl/nexys_starship_spawner.sv
// Spawn-request generator feeding the four monster state machines.
// An LFSR picks a direction, occupied directions are skipped, and the spawn interval shrinks as the game goes on.
module nexys_starship_spawner #(
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          INIT_INTERVAL = 8,
    parameter int          MIN_INTERVAL  = 2,
    parameter int          RAMP_PERIOD   = 16
) (
    input  logic       timer_clk,
    input  logic       Reset,
    input  logic       play_flag,
    input  logic       gameover_ctrl,
    input  logic [3:0] occupied,
    output logic [3:0] spawn_random,
    output logic [7:0] spawn_count,
    output logic [3:0] cur_interval,
    output logic       q_Idle,
    output logic       q_Run,
    output logic       q_Over
);

    // An all-zero seed would lock the LFSR, so it is swapped for the default.
    localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [3:0]  INIT_IV   = 4'(INIT_INTERVAL);
    localparam logic [3:0]  MIN_IV    = 4'(MIN_INTERVAL);
    localparam logic [7:0]  RAMP_LAST = 8'(RAMP_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_OVER = 2'b10
    } state_t;

    state_t      state, state_n;
    logic [15:0] lfsr, lfsr_n;
    logic [3:0]  countdown, countdown_n;
    logic [3:0]  cur_interval_n;
    logic [7:0]  ramp_cnt, ramp_cnt_n;
    logic [7:0]  spawn_count_n;
    logic [3:0]  spawn_random_n;
    logic [4:0]  pick;

    // Returns {hit, one-hot} for the first free direction starting at d and wrapping.
    function automatic logic [4:0] pick_free(input logic [1:0] d, input logic [3:0] occ);
        logic [1:0] idx;
        logic [4:0] res;
        res = 5'b0;
        for (int k = 3; k >= 0; k--) begin
            idx = d + 2'(k);
            if (!occ[idx]) res = {1'b1, 4'b0001 << idx};
        end
        return res;
    endfunction

    assign pick = pick_free(lfsr[1:0], occupied);

    always_comb begin
        // NOTE: every next-state value gets a default first, so no path can leave one unassigned and infer a latch.
        state_n        = state;
        lfsr_n         = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        countdown_n    = countdown;
        cur_interval_n = cur_interval;
        ramp_cnt_n     = ramp_cnt;
        spawn_count_n  = spawn_count;
        spawn_random_n = 4'b0000;

        case (state)
            S_IDLE: begin
                if (play_flag) begin
                    state_n        = S_RUN;
                    countdown_n    = INIT_IV;
                    cur_interval_n = INIT_IV;
                    ramp_cnt_n     = 8'd0;
                    spawn_count_n  = 8'd0;
                end
            end
            S_RUN: begin
                if (gameover_ctrl) begin
                    state_n = S_OVER;
                end else if (countdown != 4'd0) begin
                    countdown_n = countdown - 4'd1;
                end else if (pick[4]) begin
                    spawn_random_n = pick[3:0];
                    spawn_count_n  = (spawn_count == 8'hFF) ? spawn_count : spawn_count + 8'd1;
                    // Reload uses the interval in force before any ramp step on this edge.
                    countdown_n    = cur_interval - 4'd1;
                    if (ramp_cnt == RAMP_LAST) begin
                        ramp_cnt_n = 8'd0;
                        if (cur_interval > MIN_IV) cur_interval_n = cur_interval - 4'd1;
                    end else begin
                        ramp_cnt_n = ramp_cnt + 8'd1;
                    end
                end
            end
            S_OVER: begin
                if (!gameover_ctrl && !play_flag) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            state        <= S_IDLE;
            lfsr         <= SEED;
            countdown    <= INIT_IV;
            cur_interval <= INIT_IV;
            ramp_cnt     <= 8'd0;
            spawn_count  <= 8'd0;
            spawn_random <= 4'b0000;
        end else begin
            state        <= state_n;
            lfsr         <= lfsr_n;
            countdown    <= countdown_n;
            cur_interval <= cur_interval_n;
            ramp_cnt     <= ramp_cnt_n;
            spawn_count  <= spawn_count_n;
            spawn_random <= spawn_random_n;
        end
    end

    assign q_Idle = (state == S_IDLE);
    assign q_Run  = (state == S_RUN);
    assign q_Over = (state == S_OVER);

endmodule

// File: tb/tb_nexys_starship_spawner.sv
// Directed testbench for nexys_starship_spawner: timing, blocking, wrap, ramp, game over and reset replay.
// Inputs change and outputs are sampled on the falling edge of timer_clk.
module tb_nexys_starship_spawner;

    logic       timer_clk = 1'b0;
    logic       Reset;
    logic       play_flag;
    logic       gameover_ctrl;
    logic [3:0] occupied;
    logic [3:0] spawn_random;
    logic [7:0] spawn_count;
    logic [3:0] cur_interval;
    logic       q_Idle, q_Run, q_Over;

    nexys_starship_spawner dut (
        .timer_clk    (timer_clk),
        .Reset        (Reset),
        .play_flag    (play_flag),
        .gameover_ctrl(gameover_ctrl),
        .occupied     (occupied),
        .spawn_random (spawn_random),
        .spawn_count  (spawn_count),
        .cur_interval (cur_interval),
        .q_Idle       (q_Idle),
        .q_Run        (q_Run),
        .q_Over       (q_Over)
    );

    always #5 timer_clk = ~timer_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference LFSR; m_prev holds the value the DUT sampled on the most recent edge.
    logic [15:0] m_lfsr, m_prev;
    always @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    function automatic logic [3:0] exp_dir(input logic [1:0] d, input logic [3:0] occ);
        logic [1:0] i;
        for (int k = 0; k < 4; k++) begin
            i = d + 2'(k);
            if (!occ[i]) return 4'b0001 << i;
        end
        return 4'b0000;
    endfunction

    task automatic step();
        @(negedge timer_clk);
    endtask

    task automatic do_reset();
        Reset         = 1'b1;
        play_flag     = 1'b0;
        gameover_ctrl = 1'b0;
        occupied      = 4'b0000;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic start_game();
        play_flag = 1'b1;
        step();
        play_flag = 1'b0;
    endtask

    task automatic wait_spawn(input int budget, output int edges, output bit dir_ok);
        edges = 0;
        do begin
            step();
            edges++;
        end while (spawn_random == 4'b0000 && edges < budget);
        check("spawn_timeout", 32'(spawn_random != 4'b0000), 1);
        dir_ok = (spawn_random == exp_dir(m_prev[1:0], occupied));
    endtask

    int         e;
    bit         ok;
    int         blocked;
    int         bad;
    bit         found;
    int         gap_at [1:260];
    logic [3:0] iv_at  [1:260];
    logic [7:0] cnt_at [1:260];
    logic [3:0] rec_val[3];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state and first three spawns.
        do_reset();
        check("rst_state", {q_Idle, q_Run, q_Over}, 3'b100);
        check("rst_spawn", spawn_random, 4'b0000);
        check("rst_count", spawn_count, 0);
        check("rst_interval", cur_interval, 8);
        start_game();
        check("enter_run", {q_Idle, q_Run, q_Over}, 3'b010);
        for (int s = 1; s <= 3; s++) begin
            wait_spawn(20, e, ok);
            check($sformatf("gap_%0d", s), e, (s == 1) ? 9 : 8);
            check($sformatf("dir_%0d", s), ok, 1);
            check($sformatf("count_%0d", s), spawn_count, s);
        end

        // All four occupied: no spawn until bottom frees up.
        occupied = 4'b1111;
        blocked  = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (spawn_random != 4'b0000) blocked++;
        end
        check("full_no_spawn", blocked, 0);
        occupied = 4'b1101;
        step();
        check("release_bottom", spawn_random, 4'b0010);
        check("release_count", spawn_count, 4);
        occupied = 4'b0000;
        wait_spawn(20, e, ok);
        check("reload_gap", e, 8);
        check("reload_dir", ok, 1);

        // Candidate 3 with right occupied wraps around to top.
        occupied = 4'b1111;
        blocked  = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (spawn_random != 4'b0000) blocked++;
        end
        check("full_no_spawn2", blocked, 0);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (m_lfsr[1:0] == 2'b11) found = 1'b1;
            else step();
        end
        check("lfsr_find_3", found, 1);
        occupied = 4'b1000;
        step();
        check("wrap_top", spawn_random, 4'b0001);
        check("wrap_count", spawn_count, 6);

        // Difficulty ramp, interval floor and count saturation.
        do_reset();
        start_game();
        bad = 0;
        for (int s = 1; s <= 260; s++) begin
            wait_spawn(20, e, ok);
            gap_at[s] = e;
            iv_at[s]  = cur_interval;
            cnt_at[s] = spawn_count;
            if (!ok) bad++;
        end
        check("ramp_dir_errors", bad, 0);
        check("iv_after_15", iv_at[15], 8);
        check("iv_after_16", iv_at[16], 7);
        check("gap_16_17", gap_at[17], 8);
        check("gap_17_18", gap_at[18], 7);
        check("iv_after_95", iv_at[95], 3);
        check("iv_after_96", iv_at[96], 2);
        check("iv_floor_112", iv_at[112], 2);
        check("iv_floor_260", iv_at[260], 2);
        check("gap_at_floor", gap_at[260], 2);
        check("count_254", cnt_at[254], 254);
        check("count_sat_255", cnt_at[255], 255);
        check("count_sat_260", cnt_at[260], 255);

        // Game over on the edge where countdown is zero.
        do_reset();
        start_game();
        repeat (8) step();
        check("pre_over_no_spawn", spawn_random, 4'b0000);
        gameover_ctrl = 1'b1;
        step();
        check("over_state", {q_Idle, q_Run, q_Over}, 3'b001);
        check("over_spawn", spawn_random, 4'b0000);
        check("over_count", spawn_count, 0);
        gameover_ctrl = 1'b0;
        play_flag     = 1'b1;
        step();
        check("over_hold_play", {q_Idle, q_Run, q_Over}, 3'b001);
        check("over_interval", cur_interval, 8);
        play_flag = 1'b0;
        step();
        check("over_to_idle", {q_Idle, q_Run, q_Over}, 3'b100);

        // Reset in the middle of a left spawn, then replay from the seed.
        do_reset();
        start_game();
        for (int s = 0; s < 3; s++) begin
            wait_spawn(20, e, ok);
            rec_val[s] = spawn_random;
            check($sformatf("run1_dir_%0d", s), ok, 1);
        end
        occupied = 4'b1011;
        wait_spawn(20, e, ok);
        check("left_only", spawn_random, 4'b0100);
        #2 Reset = 1'b1;
        #1;
        check("async_spawn", spawn_random, 4'b0000);
        check("async_count", spawn_count, 0);
        check("async_interval", cur_interval, 8);
        check("async_state", {q_Idle, q_Run, q_Over}, 3'b100);
        check("async_lfsr", dut.lfsr, 16'hACE1);
        step();
        Reset    = 1'b0;
        occupied = 4'b0000;
        start_game();
        for (int s = 0; s < 3; s++) begin
            wait_spawn(20, e, ok);
            check($sformatf("replay_gap_%0d", s), e, (s == 0) ? 9 : 8);
            check($sformatf("replay_dir_%0d", s), ok, 1);
            check($sformatf("replay_same_%0d", s), spawn_random, rec_val[s]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nexys_starship_spawner.md
Name: nexys_starship_spawner

Overview:
- Upstream stage for the four monster state machines (top/bottom/left/right).
- Generates the per-direction random spawn requests (bottom bit feeds btm_random) on the slow timer_clk.
- Uses an LFSR direction pick, skips occupied directions, and ramps difficulty by shortening the spawn interval as the game progresses.
- Follows the game's play/gameover lifecycle.

Parameters:
- LFSR_SEED, 16'hACE1, initial LFSR value; a seed of 0 is replaced by 16'hACE1.
- INIT_INTERVAL, 8, starting spawn interval in timer_clk ticks; legal range 2..15.
- MIN_INTERVAL, 2, floor for the interval; 1..INIT_INTERVAL.
- RAMP_PERIOD, 16, number of spawns between interval decrements; 1..255.

Ports:
- timer_clk, in, 1, slow game tick clock.
- Reset, in, 1, asynchronous, active-high.
- play_flag, in, 1, start-game request.
- gameover_ctrl, in, 1, game over from any monster SM.
- occupied, in, 4, monster currently present; bit0 top, bit1 bottom, bit2 left, bit3 right.
- spawn_random, out, 4, one-hot spawn request, registered; same bit order; bit1 drives btm_random.
- spawn_count, out, 8, total spawns this game, saturating at 255.
- cur_interval, out, 4, current spawn interval.
- q_Idle, q_Run, q_Over, out, 1 each, one-hot state.

Behaviour:
- Reset values:
  - state IDLE (q_Idle=1).
  - spawn_random=0, spawn_count=0.
  - cur_interval=INIT_INTERVAL, countdown=INIT_INTERVAL, ramp_cnt=0.
  - lfsr=LFSR_SEED.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Feedback = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]; shift left with feedback into bit0.
  - Advances on every timer_clk edge in all states, reset excepted.
  - Never reaches 0.
- spawn_random is 0 on every edge unless a spawn occurs on that edge. It is high for exactly one timer_clk period, long enough for the Clk-domain SMs to sample.
- IDLE:
  - play_flag=1 -> RUN.
  - On that edge load countdown=INIT_INTERVAL, cur_interval=INIT_INTERVAL, ramp_cnt=0, spawn_count=0.
- RUN, priority order per edge:
  1. gameover_ctrl=1 -> OVER. spawn_random=0; no spawn, even if countdown=0.
  2. countdown!=0 -> countdown decrements.
  3. countdown=0 -> spawn attempt:
     - Candidate d = lfsr[1:0], sampled before this edge's shift.
     - Select the first unoccupied direction of d, d+1, d+2, d+3 (mod 4).
     - On success: set spawn_random bit; spawn_count+1 (saturating); countdown=cur_interval-1.
     - Also on success, ramp_cnt+1. If ramp_cnt was RAMP_PERIOD-1: ramp_cnt=0 and cur_interval decrements if cur_interval>MIN_INTERVAL. The reload on this edge uses the pre-decrement interval.
     - If all four directions are occupied: no spawn; countdown stays 0; retry next edge.
- Timing:
  - First spawn is on edge INIT_INTERVAL+1 after the RUN-entry edge.
  - Steady-state spacing between successive spawns is cur_interval edges, when unblocked.
- OVER:
  - Outputs held: spawn_random=0; spawn_count and cur_interval frozen.
  - gameover_ctrl=0 and play_flag=0 -> IDLE.
- Reset mid-operation: asynchronous return to all reset values. Any pending spawn is lost.
- Unreachable state encodings return to IDLE on the next edge.

Test Plan:
- Reset, then play_flag=1 for one tick, occupied=0: q_Run=1 after 1 edge. Exactly one spawn_random bit high on edge 9 after entry, then every 8 edges. spawn_count increments 1,2,3.
- occupied=4'b1111 when countdown reaches 0: no spawn while full. Release occupied[1] only: spawn_random=4'b0010 on the next edge; countdown reloads to 7.
- Force lfsr[1:0]=2'b11 with occupied=4'b1000: spawn_random=4'b0001 (wraps to top).
- 16 unblocked spawns from INIT_INTERVAL=8: cur_interval=7 after the 16th spawn; 16th-to-17th spacing is still 8, 17th-to-18th is 7. Run to floor: cur_interval stops at 2.
- gameover_ctrl=1 on the same edge countdown=0: q_Over=1, spawn_random=0, spawn_count unchanged. Hold play_flag=1: stays in OVER. Drop both inputs: IDLE.
- Assert Reset mid-RUN while spawn_random=4'b0100: all outputs drop immediately to reset values. lfsr returns to 16'hACE1, giving an identical spawn sequence on replay.
